// File: rtl/fstore_pkg.sv
// Shared definitions for the DVI capture path.
//  - Capture FSM state encoding.
//  - Default buffer address width and position counter width.
//  - Bit positions of the colour MSBs inside the two DVI half-words. The display
//    driver uses the same mapping: low half = {g[3:0], b[7:0]}, high half = {r[7:0], g[7:4]}.
//  - pix_bit(): thresholds a reassembled pixel to one bit.
package fstore_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int POS_W_DEF  = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  localparam int DVI_LO_B7 = 7;   // b[7] within the low half-word
  localparam int DVI_HI_R7 = 11;  // r[7] within the high half-word
  localparam int DVI_HI_G7 = 3;   // g[7] within the high half-word

  // A pixel is "lit" when any colour channel has its MSB set.
  function automatic logic pix_bit(input logic [11:0] lo, input logic [11:0] hi);
    return lo[DVI_LO_B7] | hi[DVI_HI_R7] | hi[DVI_HI_G7];
  endfunction

endpackage

// File: rtl/dvi_pix_packer.sv
// Packs 1-bit pixels into 64-bit words and drives the capture buffer write port.
// Ports:
//  pixel2_clk, irst   clock and synchronous active-high reset
//  start              clears word, address and overflow (a new capture is armed)
//  drop               discards any partial word and pending write (capture aborted)
//  bit_valid/bit_in   one in-window pixel bit
//  bit_last           this bit is the last in-window pixel of its line: flush
//  line_end           active video of a line ended: flush any leftover partial word
//  wr_en/wr_we/wr_addr/wr_data  buffer write port, bit 0 = leftmost pixel
//  overflow           sticky: a word was dropped because the buffer was full
module dvi_pix_packer
  import fstore_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              pixel2_clk,
  input  logic              irst,
  input  logic              start,
  input  logic              drop,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              bit_last,
  input  logic              line_end,
  output logic              wr_en,
  output logic [7:0]        wr_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [63:0]       wr_data,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic [63:0]       shift_reg;
  logic [5:0]        cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              wr_en_reg;
  logic [63:0]       wr_data_reg;
  logic              full_reg;
  logic              ovf_reg;

  logic [63:0]       word_next;
  logic              emit;
  logic              full_now;

  // Bits above cnt are always zero, so a flushed partial word is zero-padded.
  always_comb begin
    word_next = shift_reg;
    emit      = 1'b0;
    if (bit_valid) begin
      word_next[cnt_reg] = bit_in;
      emit = bit_last || (cnt_reg == 6'd63);
    end else if (line_end && (cnt_reg != 6'd0)) begin
      emit = 1'b1;
    end
  end

  // The write to the last address may still be on the port this cycle.
  assign full_now = full_reg | (wr_en_reg & (addr_reg == ADDR_MAX));

  always_ff @(posedge pixel2_clk) begin
    if (irst) begin
      shift_reg   <= '0;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      wr_en_reg   <= 1'b0;
      wr_data_reg <= '0;
      full_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else if (start || drop) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      wr_en_reg <= 1'b0;
      if (start) begin
        addr_reg <= '0;
        full_reg <= 1'b0;
        ovf_reg  <= 1'b0;
      end
    end else begin
      wr_en_reg <= 1'b0;
      // Address advances after the write cycle; it parks on the last word.
      if (wr_en_reg) begin
        if (addr_reg == ADDR_MAX) begin
          full_reg <= 1'b1;
        end else begin
          addr_reg <= addr_reg + 1'b1;
        end
      end
      if (emit) begin
        shift_reg <= '0;
        cnt_reg   <= '0;
        if (full_now) begin
          ovf_reg <= 1'b1;
        end else begin
          wr_en_reg   <= 1'b1;
          wr_data_reg <= word_next;
        end
      end else if (bit_valid) begin
        shift_reg <= word_next;
        cnt_reg   <= cnt_reg + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_we
      assign wr_we[gi] = wr_en_reg;
    end
  endgenerate

  assign wr_en    = wr_en_reg;
  assign wr_addr  = addr_reg;
  assign wr_data  = wr_data_reg;
  assign overflow = ovf_reg;

endmodule

// File: rtl/dvi_capture.sv
// Receive side of the 12-bit double-pumped DVI bus. Reassembles pixels from
// half-words, tracks sync/active area, thresholds pixels to 1 bit and captures a
// programmable window of one frame into a 64-bit-wide buffer.
// Ports:
//  pixel2_clk, irst          clock and synchronous active-high reset
//  dvi_d/de/h/v/xclk_p       DVI half-pixel bus (xclk_p=1 low half, 0 high half)
//  arm, abort                control pulses
//  win_x0/y0/w/h             capture window, latched on an accepted arm
//  busy, done, overflow, phase_err   status
//  h_active, v_active        measured active pixels per line / lines per frame
//  wr_en/we/addr/data        capture buffer write port
module dvi_capture
  import fstore_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int POS_W  = POS_W_DEF
) (
  input  logic              pixel2_clk,
  input  logic              irst,
  input  logic [11:0]       dvi_d,
  input  logic              dvi_de,
  input  logic              dvi_h,
  input  logic              dvi_v,
  input  logic              dvi_xclk_p,
  input  logic              arm,
  input  logic              abort,
  input  logic [POS_W-1:0]  win_x0,
  input  logic [POS_W-1:0]  win_y0,
  input  logic [POS_W-1:0]  win_w,
  input  logic [POS_W-1:0]  win_h,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              phase_err,
  output logic [POS_W-1:0]  h_active,
  output logic [POS_W-1:0]  v_active,
  output logic              wr_en,
  output logic [7:0]        wr_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [63:0]       wr_data
);

  logic [11:0]      d_reg;
  logic             de_reg, h_reg, v_reg, xclk_reg;
  logic             de_prev_reg, v_prev_reg;
  logic [11:0]      lo_reg;
  logic             lo_valid_reg;
  logic [POS_W-1:0] hpos_reg, vpos_reg, h_active_reg, v_active_reg;
  logic [POS_W-1:0] x0_reg, y0_reg;
  logic [POS_W:0]   x_end_reg, y_end_reg;
  logic             empty_reg;
  logic             done_reg, perr_reg;
  cap_state_t       state_reg, state_next;

  logic de_rise, de_fall, v_rise;
  logic pix_valid, orphan_hi, pix_val;
  logic in_win, last_in_win, win_end, line_end;
  logic arm_ok, cap_exit;

  // Input stage: everything downstream works on these registered copies.
  always_ff @(posedge pixel2_clk) begin
    if (irst) begin
      d_reg       <= '0;
      de_reg      <= 1'b0;
      h_reg       <= 1'b0;
      v_reg       <= 1'b0;
      xclk_reg    <= 1'b0;
      de_prev_reg <= 1'b0;
      v_prev_reg  <= 1'b0;
    end else begin
      d_reg       <= dvi_d;
      de_reg      <= dvi_de;
      h_reg       <= dvi_h;
      v_reg       <= dvi_v;
      xclk_reg    <= dvi_xclk_p;
      de_prev_reg <= de_reg;
      v_prev_reg  <= v_reg;
    end
  end

  assign de_rise = de_reg & ~de_prev_reg;
  assign de_fall = ~de_reg & de_prev_reg;
  assign v_rise  = v_reg & ~v_prev_reg;

  // Low half is only good for the very next cycle; a half-pixel never
  // survives across blanking or an hsync.
  always_ff @(posedge pixel2_clk) begin
    if (irst) begin
      lo_reg       <= '0;
      lo_valid_reg <= 1'b0;
    end else begin
      lo_valid_reg <= de_reg & xclk_reg & ~h_reg;
      if (de_reg && xclk_reg) begin
        lo_reg <= d_reg;
      end
    end
  end

  assign pix_valid = de_reg & ~xclk_reg & lo_valid_reg;
  assign orphan_hi = de_reg & ~xclk_reg & ~lo_valid_reg;
  assign pix_val   = pix_bit(lo_reg, d_reg);

  always_ff @(posedge pixel2_clk) begin
    if (irst) begin
      hpos_reg     <= '0;
      vpos_reg     <= '0;
      h_active_reg <= '0;
      v_active_reg <= '0;
    end else begin
      if (de_rise) begin
        hpos_reg <= '0;
      end else if (pix_valid) begin
        hpos_reg <= hpos_reg + 1'b1;
      end
      if (de_fall) begin
        h_active_reg <= hpos_reg;
      end
      if (v_rise) begin
        vpos_reg     <= '0;
        v_active_reg <= vpos_reg;
      end else if (de_fall) begin
        vpos_reg <= vpos_reg + 1'b1;
      end
    end
  end

  // Window bounds are held one bit wider so x0+w / y0+h never wrap.
  assign in_win = (state_reg == ST_CAPTURE) && pix_valid && !abort &&
                  (vpos_reg >= y0_reg) && ({1'b0, vpos_reg} < y_end_reg) &&
                  (hpos_reg >= x0_reg) && ({1'b0, hpos_reg} < x_end_reg);
  assign last_in_win = (({1'b0, hpos_reg} + 1'b1) == x_end_reg);
  // The line that just ended was the last window line. An empty window never
  // ends early and waits for the end of the frame.
  assign win_end  = de_fall && !empty_reg && (({1'b0, vpos_reg} + 1'b1) == y_end_reg);
  assign line_end = de_fall && (state_reg == ST_CAPTURE) && !abort;

  always_comb begin
    state_next = state_reg;
    arm_ok     = 1'b0;
    cap_exit   = 1'b0;
    unique case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          arm_ok     = 1'b1;
          state_next = ST_WAIT_VS;
        end
      end
      ST_WAIT_VS: begin
        if (v_rise) begin
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (v_rise || win_end) begin
          cap_exit   = 1'b1;
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (abort) begin
      state_next = ST_IDLE;
      arm_ok     = 1'b0;
      cap_exit   = 1'b0;
    end
  end

  always_ff @(posedge pixel2_clk) begin
    if (irst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge pixel2_clk) begin
    if (irst) begin
      x0_reg    <= '0;
      y0_reg    <= '0;
      x_end_reg <= '0;
      y_end_reg <= '0;
      empty_reg <= 1'b0;
      done_reg  <= 1'b0;
      perr_reg  <= 1'b0;
    end else begin
      if (arm_ok) begin
        x0_reg    <= win_x0;
        y0_reg    <= win_y0;
        x_end_reg <= {1'b0, win_x0} + {1'b0, win_w};
        y_end_reg <= {1'b0, win_y0} + {1'b0, win_h};
        empty_reg <= (win_w == '0) || (win_h == '0);
        done_reg  <= 1'b0;
        perr_reg  <= 1'b0;
      end
      if (cap_exit) begin
        done_reg <= 1'b1;
      end
      if (orphan_hi) begin
        perr_reg <= 1'b1;
      end
    end
  end

  dvi_pix_packer #(
    .ADDR_W(ADDR_W)
  ) u_packer (
    .pixel2_clk(pixel2_clk),
    .irst      (irst),
    .start     (arm_ok),
    .drop      (abort),
    .bit_valid (in_win),
    .bit_in    (pix_val),
    .bit_last  (last_in_win),
    .line_end  (line_end),
    .wr_en     (wr_en),
    .wr_we     (wr_we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .overflow  (overflow)
  );

  assign busy      = (state_reg == ST_WAIT_VS) || (state_reg == ST_CAPTURE);
  assign done      = done_reg;
  assign phase_err = perr_reg;
  assign h_active  = h_active_reg;
  assign v_active  = v_active_reg;

endmodule

// File: tb/tb_dvi_capture.sv
module tb_dvi_capture;

  localparam int ADDR_W = 5;
  localparam int POS_W  = 12;
  localparam int CAP    = 32;
  localparam int MAXH   = 160;
  localparam int MAXV   = 12;
  localparam int LOGN   = 1024;

  logic              pixel2_clk = 1'b0;
  logic              irst;
  logic [11:0]       dvi_d;
  logic              dvi_de, dvi_h, dvi_v, dvi_xclk_p;
  logic              arm, abort;
  logic [POS_W-1:0]  win_x0, win_y0, win_w, win_h;
  logic              busy, done, overflow, phase_err;
  logic [POS_W-1:0]  h_active, v_active;
  logic              wr_en;
  logic [7:0]        wr_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0]       wr_data;

  always #5 pixel2_clk = ~pixel2_clk;

  dvi_capture #(.ADDR_W(ADDR_W), .POS_W(POS_W)) dut (
    .pixel2_clk(pixel2_clk), .irst(irst),
    .dvi_d(dvi_d), .dvi_de(dvi_de), .dvi_h(dvi_h), .dvi_v(dvi_v), .dvi_xclk_p(dvi_xclk_p),
    .arm(arm), .abort(abort),
    .win_x0(win_x0), .win_y0(win_y0), .win_w(win_w), .win_h(win_h),
    .busy(busy), .done(done), .overflow(overflow), .phase_err(phase_err),
    .h_active(h_active), .v_active(v_active),
    .wr_en(wr_en), .wr_we(wr_we), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Write-port log, filled only by this monitor.
  logic [ADDR_W-1:0] log_addr [0:LOGN-1];
  logic [63:0]       log_data [0:LOGN-1];
  logic [7:0]        log_we   [0:LOGN-1];
  int                wr_cnt = 0;

  always @(negedge pixel2_clk) begin
    if (wr_en) begin
      if (wr_cnt < LOGN) begin
        log_addr[wr_cnt] <= wr_addr;
        log_data[wr_cnt] <= wr_data;
        log_we[wr_cnt]   <= wr_we;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Reference data: frame pixels and the words the window should produce.
  logic [23:0] pix [0:MAXV-1][0:MAXH-1];
  logic [63:0] exp_data [0:255];
  int          exp_n;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pixel2_clk);
  endtask

  function automatic logic pbit(input logic [23:0] p);
    return p[23] | p[15] | p[7];  // r[7] | g[7] | b[7]
  endfunction

  task automatic fill(input int hh, input int vv, input bit white);
    logic [23:0] p;
    for (int y = 0; y < vv; y++) begin
      for (int x = 0; x < hh; x++) begin
        p = 24'($urandom);
        if ($urandom_range(0, 1) == 1) p = p & 24'h7F7F7F;
        pix[y][x] = white ? 24'hFFFFFF : p;
      end
    end
  endtask

  // Each window row is cut into 64-pixel words, leftmost pixel in bit 0,
  // remainder zero-padded; rows and pixels outside the frame contribute nothing.
  task automatic build_model(input int hh, input int vv, input int x0, input int y0,
                             input int w, input int h);
    int xe, ye, k;
    logic [63:0] word;
    exp_n = 0;
    if (w == 0 || h == 0) return;
    xe = (x0 + w < hh) ? x0 + w : hh;
    ye = (y0 + h < vv) ? y0 + h : vv;
    for (int y = y0; y < ye; y++) begin
      k = 0;
      word = '0;
      for (int x = x0; x < xe; x++) begin
        word[k] = pbit(pix[y][x]);
        k++;
        if (k == 64) begin
          exp_data[exp_n] = word;
          exp_n++;
          word = '0;
          k = 0;
        end
      end
      if (k != 0) begin
        exp_data[exp_n] = word;
        exp_n++;
      end
    end
  endtask

  task automatic do_arm(input int x0, input int y0, input int w, input int h);
    win_x0 = POS_W'(x0);
    win_y0 = POS_W'(y0);
    win_w  = POS_W'(w);
    win_h  = POS_W'(h);
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic drive_vsync();
    dvi_v = 1'b1;
    tick(6);
    dvi_v = 1'b0;
    tick(4);
  endtask

  task automatic drive_line(input int y, input int hh, input bit orphan, input bit arm_pulse);
    dvi_h = 1'b1;
    if (arm_pulse) begin
      win_x0 = 12'd3; win_y0 = 12'd0; win_w = 12'd7; win_h = 12'd1;
      arm = 1'b1;
    end
    tick(1);
    arm = 1'b0;
    tick(1);
    dvi_h = 1'b0;
    tick(3);
    if (orphan) begin
      dvi_de = 1'b1; dvi_xclk_p = 1'b0; dvi_d = 12'hFFF;
      tick(1);
    end
    for (int x = 0; x < hh; x++) begin
      dvi_de = 1'b1; dvi_xclk_p = 1'b1; dvi_d = pix[y][x][11:0];
      tick(1);
      dvi_xclk_p = 1'b0; dvi_d = pix[y][x][23:12];
      tick(1);
    end
    dvi_de = 1'b0; dvi_d = '0;
    tick(3);
  endtask

  task automatic run_capture(input string tag, input int hh, input int vv, input int x0,
                             input int y0, input int w, input int h, input bit white,
                             input int arm_line);
    int base, nexp;
    bit early;
    fill(hh, vv, white);
    build_model(hh, vv, x0, y0, w, h);
    nexp  = (exp_n < CAP) ? exp_n : CAP;
    early = (w != 0) && (h != 0) && (y0 + h <= vv);
    base  = wr_cnt;
    do_arm(x0, y0, w, h);
    chk({tag, "_busy_armed"}, 64'(busy), 64'(1));
    chk({tag, "_perr_clr"}, 64'(phase_err), 64'(0));
    drive_vsync();
    for (int y = 0; y < vv; y++) drive_line(y, hh, 1'b0, y == arm_line);
    tick(4);
    chk({tag, "_done_early"}, 64'(done), 64'(early));
    drive_vsync();
    tick(4);
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    chk({tag, "_overflow"}, 64'(overflow), 64'(exp_n > CAP));
    chk({tag, "_h_active"}, 64'(h_active), 64'(hh));
    chk({tag, "_v_active"}, 64'(v_active), 64'(vv));
    chk({tag, "_wr_count"}, 64'(wr_cnt - base), 64'(nexp));
    for (int i = 0; i < nexp && base + i < LOGN; i++) begin
      chk({tag, "_addr"}, 64'(log_addr[base + i]), 64'(i));
      chk({tag, "_data"}, log_data[base + i], exp_data[i]);
      chk({tag, "_we"}, 64'(log_we[base + i]), 64'(8'hFF));
    end
    if (exp_n < CAP) chk({tag, "_end_addr"}, 64'(wr_addr), 64'(exp_n));
    $display("run %s: %0dx%0d win x0=%0d y0=%0d w=%0d h=%0d words=%0d", tag, hh, vv, x0, y0, w, h, exp_n);
  endtask

  initial begin
    int base, hh, vv, x0, y0, w, h;
    irst = 1'b1;
    dvi_d = '0; dvi_de = 1'b0; dvi_h = 1'b0; dvi_v = 1'b0; dvi_xclk_p = 1'b0;
    arm = 1'b0; abort = 1'b0;
    win_x0 = '0; win_y0 = '0; win_w = '0; win_h = '0;
    tick(4);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_perr", 64'(phase_err), 64'(0));
    chk("rst_h_active", 64'(h_active), 64'(0));
    chk("rst_v_active", 64'(v_active), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr_we", 64'(wr_we), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", wr_data, 64'(0));
    irst = 1'b0;
    tick(2);

    // White field, narrow two-line window: 64 ones then 36 ones per line.
    run_capture("white_win", 128, 4, 10, 0, 100, 2, 1'b1, -1);
    chk("white_w0", exp_data[0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("white_w1", exp_data[1], 64'h0000_000F_FFFF_FFFF);

    // Full-frame window larger than the buffer.
    run_capture("overflow", 150, 12, 0, 0, 150, 12, 1'b1, -1);

    // Empty window captures nothing but still completes at end of frame.
    run_capture("empty_w", 40, 3, 0, 0, 0, 3, 1'b0, -1);

    // Abort shortly after entering capture.
    fill(100, 4, 1'b1);
    do_arm(0, 0, 100, 4);
    base = wr_cnt;
    dvi_v = 1'b1;
    tick(2);
    chk("abort_busy_pre", 64'(busy), 64'(1));
    tick(4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    dvi_v = 1'b0;
    tick(4);
    for (int y = 0; y < 4; y++) drive_line(y, 100, 1'b0, 1'b0);
    tick(4);
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_writes", 64'(wr_cnt - base), 64'(0));
    $display("abort: writes after abort=%0d", wr_cnt - base);

    // Restart after abort begins at address 0 again.
    run_capture("after_abort", 90, 3, 5, 1, 80, 2, 1'b0, -1);

    // Orphan high half at the start of a line.
    fill(30, 1, 1'b0);
    drive_line(0, 30, 1'b1, 1'b0);
    tick(2);
    chk("orphan_perr", 64'(phase_err), 64'(1));
    chk("orphan_h_active", 64'(h_active), 64'(30));
    $display("orphan: phase_err=%0d h_active=%0d", phase_err, h_active);

    // Arm pulse during capture must be ignored.
    run_capture("arm_busy", 120, 5, 4, 1, 110, 3, 1'b0, 2);

    // Random frames and windows.
    for (int r = 0; r < 8; r++) begin
      hh = $urandom_range(20, 150);
      vv = $urandom_range(3, 8);
      x0 = $urandom_range(0, hh + 4);
      w  = $urandom_range(0, hh);
      y0 = $urandom_range(0, vv);
      h  = $urandom_range(0, vv + 2);
      run_capture($sformatf("rand%0d", r), hh, vv, x0, y0, w, h, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
